// File: rtl/isqrt_result_buffer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | isqrt_result_buffer_pkg : shared defaults and pointer helper          |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package isqrt_result_buffer_pkg;

    localparam int unsigned DEFAULT_DEPTH = 16;
    localparam int unsigned DEFAULT_W     = 16;

    // Wrap-bit pointers: full when only the bit above the index differs.
    function automatic logic ptrs_full(input logic [31:0] wr, input logic [31:0] rd,
                                       input int unsigned aw);
        logic [31:0] msb;
        logic [31:0] mask;
        msb  = 32'd1 << aw;
        mask = (msb << 1) - 32'd1;
        return ((wr ^ rd) & mask) == msb;
    endfunction

endpackage
`default_nettype wire

// File: rtl/isqrt_result_buffer_sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | isqrt_sync_fifo : show-ahead result FIFO with sticky overflow flag    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module isqrt_sync_fifo
    import isqrt_result_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned W     = DEFAULT_W
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop_req,
    output logic                     out_valid,
    output logic [W-1:0]             out_y,
    output logic                     pop,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic         overflow_q, overflow_d;
    logic         empty;
    logic         full;
    logic         push_ok;

    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = ptrs_full(32'(wr_ptr_q), 32'(rd_ptr_q), AW);
    assign pop       = pop_req & ~empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign push_ok   = push & (~full | pop);

    assign out_valid = ~empty;
    assign out_y     = mem_q[rd_ptr_q[AW-1:0]];
    assign count     = wr_ptr_q - rd_ptr_q;
    assign overflow  = overflow_q;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (push && !push_ok) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            mem_q      <= '{default: '0};
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
            if (push_ok) begin
                mem_q[wr_ptr_q[AW-1:0]] <= push_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/isqrt_result_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | isqrt_result_buffer : credit-gated issue to the isqrt pipeline plus   |
// | buffered valid/ready result delivery                                  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module isqrt_result_buffer
    import isqrt_result_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned W     = DEFAULT_W
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    output logic                     run,
    input  logic                     pipe_ready,
    input  logic [W-1:0]             pipe_y,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [W-1:0]             out_y,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] CREDITS_INIT = (AW+1)'(DEPTH);
    localparam logic [AW:0] CREDIT_ONE   = {{AW{1'b0}}, 1'b1};

    logic [AW:0] credits_q, credits_d;
    logic        pop;

    // Every credit is a reserved FIFO slot, so the pipeline never needs backpressure.
    assign req_ready = (credits_q != '0);
    assign run       = req_valid & req_ready;

    always_comb begin
        credits_d = credits_q;
        if (run && !pop) begin
            credits_d = credits_q - CREDIT_ONE;
        end else if (pop && !run && (credits_q != CREDITS_INIT)) begin
            credits_d = credits_q + CREDIT_ONE;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            credits_q <= CREDITS_INIT;
        end else begin
            credits_q <= credits_d;
        end
    end

    isqrt_sync_fifo #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (pipe_ready),
        .push_data (pipe_y),
        .pop_req   (out_ready),
        .out_valid (out_valid),
        .out_y     (out_y),
        .pop       (pop),
        .count     (count),
        .overflow  (overflow)
    );

endmodule
`default_nettype wire
